key_event_scheduler: RTL and testbench

Converts debounced key levels into discrete key events: press, long-press, auto-repeat and release. Events from all keys are arbitrated round-robin into a small FIFO and presented on a valid/ready port. It sits downstream of the per-key synchronise-and-debounce stage and upstream of the UI or display logic, such as the TM1638 key handler, which consumes one event at a time.

---
 rtl/key_event_pkg.sv | 10 +
 rtl/key_event_fifo.sv | 36 +++
 rtl/key_event_scheduler.sv | 89 ++++++++
 tb/tb_key_event_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg: event, per-key state and FIFO entry types shared by the key event scheduler
package key_event_pkg;
  localparam int key_bits = 4;
  typedef enum logic [1:0] {PRESS, LONG, REPEAT, RELEASE} ev_type_t;
  typedef enum logic [1:0] {IDLE, HELD, REPEATING} key_state_t;
  typedef struct packed {
    logic [key_bits-1:0] key;
    ev_type_t kind;
  } ev_entry_t;
endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: circular event buffer; push and pop may coincide in any state, no empty bypass
module key_event_fifo #(
  parameter int width = 6,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem [depth];
  logic [aw:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = wp == {~rp[aw], rp[aw-1:0]};
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign rdata = mem[rp[aw-1:0]];
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      mem <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wp[aw-1:0]] <= wdata;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/key_event_scheduler.sv
// key_event_scheduler: turns debounced key levels into PRESS/LONG/REPEAT/RELEASE events, round-robin into a FIFO
module key_event_scheduler
  import key_event_pkg::*;
#(
  parameter int w = 8,
  parameter int long_cycles = 50_000_000,
  parameter int repeat_cycles = 10_000_000,
  parameter int fifo_depth = 4,
  localparam int kw = w > 1 ? $clog2(w) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [w-1:0]  key_in,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [kw-1:0] ev_key,
  output logic [1:0]    ev_type,
  output logic          overflow
);
  localparam int cw = $clog2(long_cycles > repeat_cycles ? long_cycles : repeat_cycles);
  logic [3:0] pend [w];
  logic [w-1:0] has, ovf;
  logic [kw-1:0] rr, gnt_key;
  logic [3:0] sel;
  logic found, grant, full, empty, pop, unused_key;
  ev_type_t gnt_type;
  ev_entry_t wr, head;
  assign pop = !empty & ev_ready;
  assign grant = found & (!full | pop);
  // Walk candidates backwards so the one closest to rr is the last (winning) assignment.
  always_comb begin
    found = 1'b0;
    gnt_key = '0;
    for (int i = w - 1; i >= 0; i--)
      if (has[kw'((int'(rr) + i) % w)]) begin
        found = 1'b1;
        gnt_key = kw'((int'(rr) + i) % w);
      end
  end
  assign sel = pend[gnt_key];
  assign gnt_type = sel[0] ? PRESS : sel[1] ? LONG : sel[2] ? REPEAT : RELEASE;
  assign wr = '{key: key_bits'(gnt_key), kind: gnt_type};
  for (genvar k = 0; k < w; k++) begin : g_key
    key_state_t st;
    logic [cw-1:0] cnt;
    logic [3:0] p, set, gnt_bits;
    // Release wins over a LONG/REPEAT that would fire in the same cycle.
    assign set = st == IDLE ? {3'b000, key_in[k]} :
                 !key_in[k] ? 4'b1000 :
                 st == HELD ? {2'b00, cnt == cw'(long_cycles - 1), 1'b0} :
                 {1'b0, cnt == cw'(repeat_cycles - 1), 2'b00};
    assign gnt_bits = grant && gnt_key == kw'(k) ? 4'b0001 << gnt_type : 4'b0000;
    assign pend[k] = p;
    assign has[k] = |p;
    assign ovf[k] = |(set & p & ~gnt_bits);
    always_ff @(posedge clk)
      if (reset) begin
        st <= IDLE;
        cnt <= '0;
        p <= '0;
      end else begin
        p <= (p & ~gnt_bits) | set;
        cnt <= st == IDLE || |set ? '0 : cnt + 1'b1;
        st <= set[PRESS] ? HELD : set[RELEASE] ? IDLE : set[LONG] ? REPEATING : st;
      end
  end
  key_event_fifo #(.width($bits(ev_entry_t)), .depth(fifo_depth)) u_fifo (
    .clk,
    .reset,
    .push(grant),
    .wdata(wr),
    .pop,
    .rdata(head),
    .full,
    .empty
  );
  assign ev_valid = !empty;
  assign ev_key = head.key[kw-1:0];
  assign ev_type = head.kind;
  assign unused_key = ^head.key;
  always_ff @(posedge clk)
    if (reset) begin
      rr <= '0;
      overflow <= 1'b0;
    end else begin
      if (grant) rr <= gnt_key == kw'(w - 1) ? '0 : gnt_key + 1'b1;
      overflow <= overflow | (|ovf);
    end
endmodule

// File: tb/tb_key_event_scheduler.sv
// tb_key_event_scheduler: directed table, corner sequences and random stimulus against a queue-based event model
module tb_key_event_scheduler;
  localparam int W = 4, L = 8, R = 4, D = 4;
  logic clk = 1'b0, reset = 1'b1, ev_ready = 1'b1;
  logic [W-1:0] key_in = '0;
  logic ev_valid, overflow;
  logic [1:0] ev_key, ev_type;

  key_event_scheduler #(.w(W), .long_cycles(L), .repeat_cycles(R), .fifo_depth(D)) dut (
    .clk, .reset, .key_in, .ev_valid, .ev_ready, .ev_key, .ev_type, .overflow
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] key;
    logic       rdy;
    logic       v;
    logic [1:0] k;
    logic [1:0] t;
  } vec_t;
  vec_t tbl [24];

  int tests = 0, fails = 0, cyc = 0, c0;
  int acc[$], acc_cyc[$];
  int lh_ev [6] = '{4, 5, 6, 6, 6, 7};
  int lh_at [6] = '{2, 10, 14, 18, 22, 23};
  int bp_ev [6] = '{0, 4, 8, 12, 3, 7};
  logic [3:0] bp_keys [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100};

  // reference model: event = key*4+type, FIFO as a queue, hold length per key
  int mq[$];
  logic [3:0] mpend [W];
  int mhold [W];
  int mrr;
  bit movf;

  function automatic void chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, req);
    end
  endfunction

  function automatic int head();
    return int'(ev_key) * 4 + int'(ev_type);
  endfunction

  function automatic void model_step();
    bit pop, can;
    int gk, gt, ev;
    if (reset) begin
      mq.delete();
      mrr = 0;
      movf = 0;
      for (int k = 0; k < W; k++) begin
        mpend[k] = 0;
        mhold[k] = 0;
      end
      return;
    end
    pop = mq.size() > 0 && ev_ready;
    can = mq.size() < D || pop;
    gk = -1;
    for (int i = 0; i < W; i++)
      if (gk < 0 && mpend[(mrr + i) % W] != 0) gk = (mrr + i) % W;
    if (pop) void'(mq.pop_front());
    if (gk >= 0 && can) begin
      gt = 0;
      while (!mpend[gk][gt]) gt++;
      mpend[gk][gt] = 1'b0;
      mq.push_back(gk * 4 + gt);
      mrr = (gk + 1) % W;
    end
    for (int k = 0; k < W; k++) begin
      ev = -1;
      if (key_in[k]) begin
        mhold[k]++;
        if (mhold[k] == 1) ev = 0;
        else if (mhold[k] == L + 1) ev = 1;
        else if (mhold[k] > L + 1 && (mhold[k] - 1 - L) % R == 0) ev = 2;
      end else begin
        if (mhold[k] > 0) ev = 3;
        mhold[k] = 0;
      end
      if (ev >= 0) begin
        if (mpend[k][ev]) movf = 1;
        mpend[k][ev] = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    if (ev_valid && ev_ready) begin
      acc.push_back(head());
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk("valid", int'(ev_valid), int'(mq.size() > 0));
    chk("overflow", int'(overflow), int'(movf));
    if (mq.size() > 0) chk("head", head(), mq[0]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_in = '0;
    ev_ready = 1'b1;
    tick();
    reset = 1'b0;
    acc.delete();
    acc_cyc.delete();
  endtask

  initial begin
    tbl = '{
      '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0},
      '{1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 2'd0},
      '{1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 2'd0},
      '{1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 2'd0},
      '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0},
      '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 2'd3},
      '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0},
      '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0},
      '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0},
      '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 2'd0},
      '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 2'd0},
      '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 2'd0},
      '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 2'd0},
      '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd3, 2'd0},
      '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0},
      '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd3},
      '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd3},
      '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 2'd3},
      '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd3},
      '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0},
      '{1'b0, 4'b1001, 1'b1, 1'b0, 2'd0, 2'd0},
      '{1'b0, 4'b1001, 1'b1, 1'b1, 2'd0, 2'd0},
      '{1'b0, 4'b1001, 1'b1, 1'b1, 2'd3, 2'd0},
      '{1'b0, 4'b1001, 1'b1, 1'b0, 2'd0, 2'd0}
    };
    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      key_in = tbl[i].key;
      ev_ready = tbl[i].rdy;
      tick();
      chk("tbl_valid", int'(ev_valid), int'(tbl[i].v));
      if (tbl[i].v || tbl[i].rst) chk("tbl_head", head(), int'(tbl[i].k) * 4 + int'(tbl[i].t));
    end

    // long hold on key 1: 21 sampled-high cycles give LONG and three REPEATs before RELEASE
    do_reset();
    c0 = cyc;
    key_in = 4'b0010;
    repeat (21) tick();
    key_in = '0;
    repeat (4) tick();
    chk("long_count", acc.size(), 6);
    for (int i = 0; i < 6 && i < acc.size(); i++) begin
      chk("long_ev", acc[i], lh_ev[i]);
      chk("long_at", acc_cyc[i] - c0, lh_at[i]);
    end
    chk("long_ovf", int'(overflow), 0);

    // backpressure: six events, FIFO fills at four, head must not move
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      key_in = bp_keys[i < 6 ? i : 5];
      tick();
      if (i >= 1) begin
        chk("bp_valid", int'(ev_valid), 1);
        chk("bp_head", head(), 0);
      end
    end
    ev_ready = 1'b1;
    repeat (6) tick();
    chk("bp_count", acc.size(), 6);
    for (int i = 0; i < 6 && i < acc.size(); i++) begin
      chk("bp_ev", acc[i], bp_ev[i]);
      chk("bp_back2back", acc_cyc[i] - acc_cyc[0], i);
    end
    chk("bp_ovf", int'(overflow), 0);
    key_in = '0;
    repeat (20) tick();

    // reset with key 0 held and two entries queued
    do_reset();
    ev_ready = 1'b0;
    key_in = 4'b0011;
    repeat (3) tick();
    chk("rst_pre_valid", int'(ev_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_head", head(), 0);
    chk("rst_ovf", int'(overflow), 0);
    tick();
    chk("rst_e0_valid", int'(ev_valid), 0);
    tick();
    chk("rst_e1_valid", int'(ev_valid), 1);
    chk("rst_e1_head", head(), 0);

    // overflow: PRESS re-raised on key 0 while still pending behind a full FIFO
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      key_in = {3'b000, i[0] == 1'b0};
      tick();
      chk("ovf_seq", int'(overflow), int'(i >= 6));
    end
    ev_ready = 1'b1;
    key_in = '0;
    repeat (12) tick();
    chk("ovf_sticky", int'(overflow), 1);

    // random levels and backpressure, with occasional resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < W; k++)
        if ($urandom_range(0, 7) == 0) key_in[k] = ~key_in[k];
      ev_ready = (n / 50) % 4 == 3 ? 1'b0 : $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 599) == 0;
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
